// File: rtl/controlador_rolhas_if.sv
// Signal bundle between the capping station and the cork stock controller.
// The controller sits on the slave side; the station/bench drives the master side.
interface controlador_rolhas_if;
    logic        habilita;
    logic        req_tampa;
    logic        lote_ok;
    logic        aciona_tampador;
    logic        tampa_ok;
    logic [6:0]  estoque;
    logic        pede_reposicao;
    logic        sem_rolhas;
    logic [15:0] total_tampadas;

    modport master (
        output habilita, req_tampa, lote_ok,
        input  aciona_tampador, tampa_ok, estoque, pede_reposicao, sem_rolhas, total_tampadas
    );

    modport slave (
        input  habilita, req_tampa, lote_ok,
        output aciona_tampador, tampa_ok, estoque, pede_reposicao, sem_rolhas, total_tampadas
    );
endinterface

// File: rtl/controlador_rolhas.sv
// Cork stock controller: sequences one capping cycle per bottle, tracks a saturating stock.
// Optional macro CONTADOR_TOTAL_EN builds the 16-bit bottles-capped counter.
module controlador_rolhas #(
    parameter int unsigned MAX_ROLHAS     = 99,
    parameter int unsigned LOTE_REPOSICAO = 15,
    parameter int unsigned LIMIAR_MIN     = 5,
    parameter int unsigned TEMPO_TAMPA    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    controlador_rolhas_if.slave   io_bus
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        TAMPANDO = 2'd1,
        CONCLUI  = 2'd2
    } estado_t;

    localparam logic [7:0] L_MAX       = 8'(MAX_ROLHAS);
    localparam logic [7:0] L_LOTE      = 8'(LOTE_REPOSICAO);
    localparam logic [6:0] L_LIMIAR    = 7'(LIMIAR_MIN);
    localparam logic [3:0] L_TEMPO_INI = 4'(TEMPO_TAMPA - 1);

    estado_t     r_estado;
    estado_t     w_prox_estado;
    logic [3:0]  r_timer;
    logic [3:0]  w_prox_timer;
    logic        w_decrementa;
    logic [6:0]  r_estoque;
    logic [6:0]  w_prox_estoque;
    logic [7:0]  w_soma;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_timer   <= '0;
            r_estoque <= '0;
        end else begin
            r_estado  <= w_prox_estado;
            r_timer   <= w_prox_timer;
            r_estoque <= w_prox_estoque;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_prox_estado = r_estado;
        w_prox_timer  = r_timer;
        w_decrementa  = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (io_bus.req_tampa && io_bus.habilita && (r_estoque != '0)) begin
                    w_prox_estado = TAMPANDO;
                    w_prox_timer  = L_TEMPO_INI;
                end
            end
            TAMPANDO: begin
                if (r_timer != '0) begin
                    w_prox_timer = r_timer - 4'd1;
                end else begin
                    w_prox_estado = CONCLUI;
                    w_decrementa  = 1'b1;
                end
            end
            CONCLUI: begin
                w_prox_estado = OCIOSO;
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    // Stock is summed 8 bits wide so refill overflow above 127 is caught before saturation;
    // the decrement never underflows because TAMPANDO is only entered with a non-zero stock.
    always_comb begin
        w_soma = {1'b0, r_estoque};
        if (w_decrementa) begin
            w_soma = w_soma - 8'd1;
        end
        if (io_bus.lote_ok) begin
            w_soma = w_soma + L_LOTE;
        end
        w_prox_estoque = (w_soma > L_MAX) ? L_MAX[6:0] : w_soma[6:0];
    end

    assign io_bus.aciona_tampador = (r_estado == TAMPANDO);
    assign io_bus.tampa_ok        = (r_estado == CONCLUI);
    assign io_bus.estoque         = r_estoque;
    assign io_bus.pede_reposicao  = (r_estoque <= L_LIMIAR);
    assign io_bus.sem_rolhas      = (r_estoque == '0);

`ifdef CONTADOR_TOTAL_EN
    logic [15:0] r_total;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total <= '0;
        end else if (r_estado == CONCLUI) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign io_bus.total_tampadas = r_total;
`else
    assign io_bus.total_tampadas = 16'd0;
`endif

endmodule

// File: tb/tb_controlador_rolhas.sv
// Self-checking bench for controlador_rolhas: table-driven vectors plus directed
// sequences for back-to-back capping, stock exhaustion and asynchronous reset.
module tb_controlador_rolhas;

    typedef struct {
        logic       h;
        logic       r;
        logic       l;
        logic       a;
        logic       ok;
        logic [6:0] est;
        logic       pede;
        logic       sem;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    controlador_rolhas_if bus();

    controlador_rolhas dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic h, input logic r, input logic l, input logic a,
                                input logic ok, input logic [6:0] est, input logic pede,
                                input logic sem);
        vec_t v;
        v.h = h; v.r = r; v.l = l; v.a = a; v.ok = ok; v.est = est; v.pede = pede; v.sem = sem;
        vecs.push_back(v);
    endfunction

    task automatic check_outs(input string tag, input logic a, input logic ok, input logic [6:0] est,
                              input logic pede, input logic sem);
        check({tag, " aciona"}, 16'(bus.aciona_tampador), 16'(a));
        check({tag, " tampa_ok"}, 16'(bus.tampa_ok), 16'(ok));
        check({tag, " estoque"}, 16'(bus.estoque), 16'(est));
        check({tag, " pede"}, 16'(bus.pede_reposicao), 16'(pede));
        check({tag, " sem"}, 16'(bus.sem_rolhas), 16'(sem));
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.habilita  = vecs[i].h;
            bus.req_tampa = vecs[i].r;
            bus.lote_ok   = vecs[i].l;
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].a, vecs[i].ok, vecs[i].est,
                       vecs[i].pede, vecs[i].sem);
        end
    endtask

    // One clock with inputs unchanged; threshold flags derived from the expected stock.
    task automatic step(input string tag, input logic a, input logic ok, input logic [6:0] est);
        @(posedge clk);
        #1;
        check_outs(tag, a, ok, est, (est <= 7'd5), (est == 7'd0));
    endtask

    task automatic capping(input string tag, input logic [6:0] est_inicial);
        repeat (4) step({tag, " tampando"}, 1'b1, 1'b0, est_inicial);
        step({tag, " conclui"}, 1'b0, 1'b1, est_inicial - 7'd1);
        step({tag, " ocioso"}, 1'b0, 1'b0, est_inicial - 7'd1);
    endtask

    initial begin
        logic [15:0] exp_total;
        n_checks = 0;
        n_errors = 0;

        // Segment A: refill sequence, saturating refill during decrement, habilita drop.
        add(0,0,1, 0,0, 7'd15, 0,0);
        add(0,0,1, 0,0, 7'd30, 0,0);
        add(0,0,1, 0,0, 7'd45, 0,0);
        add(0,0,1, 0,0, 7'd60, 0,0);
        add(0,0,1, 0,0, 7'd75, 0,0);
        add(0,0,1, 0,0, 7'd90, 0,0);
        add(0,0,1, 0,0, 7'd99, 0,0);
        add(1,1,0, 1,0, 7'd99, 0,0);   // 7
        add(1,1,0, 1,0, 7'd99, 0,0);
        add(1,1,0, 1,0, 7'd99, 0,0);
        add(1,1,0, 1,0, 7'd99, 0,0);
        add(1,1,1, 0,1, 7'd99, 0,0);   // 11: decrement + refill saturates
        add(0,0,1, 0,0, 7'd99, 0,0);   // 12: refill at ceiling
        add(1,1,0, 1,0, 7'd99, 0,0);   // 13: start, then habilita drops
        add(0,1,0, 1,0, 7'd99, 0,0);
        add(0,1,0, 1,0, 7'd99, 0,0);
        add(0,1,0, 1,0, 7'd99, 0,0);
        add(0,1,0, 0,1, 7'd98, 0,0);
        add(0,1,0, 0,0, 7'd98, 0,0);
        add(0,1,0, 0,0, 7'd98, 0,0);
        add(0,0,0, 0,0, 7'd98, 0,0);   // 20
        // Segment B: single bottle from 15.
        add(0,0,1, 0,0, 7'd15, 0,0);   // 21
        add(1,1,0, 1,0, 7'd15, 0,0);
        add(1,1,0, 1,0, 7'd15, 0,0);
        add(1,1,0, 1,0, 7'd15, 0,0);
        add(1,1,0, 1,0, 7'd15, 0,0);
        add(1,1,0, 0,1, 7'd14, 0,0);
        add(1,0,0, 0,0, 7'd14, 0,0);   // 27

        bus.habilita  = 1'b0;
        bus.req_tampa = 1'b0;
        bus.lote_ok   = 1'b0;
        reset = 1'b1;
        #12;
        check_outs("reset", 1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
        check("reset total", bus.total_tampadas, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        run_vectors(0, 20);

        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_outs("reset2", 1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        run_vectors(21, 27);

        // Back-to-back bottles with req held until the stock runs out.
        bus.habilita  = 1'b1;
        bus.req_tampa = 1'b1;
        for (int n = 14; n >= 1; n--) begin
            capping($sformatf("t3 n%0d", n), 7'(n));
        end
        repeat (3) step("t3 parado", 1'b0, 1'b0, 7'd0);
        bus.lote_ok = 1'b1;
        step("t3 lote", 1'b0, 1'b0, 7'd15);
        bus.lote_ok = 1'b0;
        capping("t3 reinicio", 7'd15);
        bus.req_tampa = 1'b0;
        step("t3 fim", 1'b0, 1'b0, 7'd14);
`ifdef CONTADOR_TOTAL_EN
        exp_total = 16'd16;
`else
        exp_total = 16'd0;
`endif
        check("t3 total", bus.total_tampadas, exp_total);

        // Asynchronous reset in the second actuator cycle.
        bus.req_tampa = 1'b1;
        step("t6 c1", 1'b1, 1'b0, 7'd14);
        step("t6 c2", 1'b1, 1'b0, 7'd14);
        #3;
        reset = 1'b1;
        #1;
        check_outs("t6 async", 1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
        check("t6 async total", bus.total_tampadas, 16'd0);
        @(posedge clk);
        #1;
        check_outs("t6 em reset", 1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        bus.req_tampa = 1'b0;
        step("t6 pos1", 1'b0, 1'b0, 7'd0);
        step("t6 pos2", 1'b0, 1'b0, 7'd0);

        bus.lote_ok = 1'b1;
        step("t6 lote", 1'b0, 1'b0, 7'd15);
        bus.lote_ok = 1'b0;
        bus.req_tampa = 1'b1;
        capping("t6 b1", 7'd15);
        capping("t6 b2", 7'd14);
        capping("t6 b3", 7'd13);
        bus.req_tampa = 1'b0;
`ifdef CONTADOR_TOTAL_EN
        exp_total = 16'd3;
`else
        exp_total = 16'd0;
`endif
        check("t6 total", bus.total_tampadas, exp_total);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
